mmio_regfile: RTL and testbench
===============================

# mmio_regfile

Parametrised processor register file with memory-mapped hardware I/O. It provides a storage array with two combinational read ports and one write port, with register 0 hardwired to zero. A configurable window of registers is driven by synchronised board inputs; each channel is either a level follower or a sticky rising-edge latch that software clears by writing. A second window of registers is exported to the display/motion logic. An optional write-to-read bypass is included. It replaces the fixed-map register file between the pipeline's decode/writeback stages and the board I/O.

## Interface
- DATA_WIDTH, 32, register width
- NUM_REGS, 32, register count (power of two, ≥ 8); AW = clog2(NUM_REGS)
- IN_BASE, 1, index of first input-mapped register
- NUM_IN, 6, number of input channels (≥ 1)
- STICKY_MASK, 6'b001111, bit i = 1 makes channel i a sticky edge latch; 0 makes it a level follower
- OUT_BASE, 11, index of first exported register
- NUM_OUT, 4, number of exported registers (≥ 1)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads
- clock  in  1  sole clock, rising edge
- ctrl_reset  in  1  synchronous, active-high reset
- ctrl_writeEnable  in  1  write strobe
- ctrl_writeReg  in  AW  write index
- data_writeReg  in  DATA_WIDTH  write data
- ctrl_readRegA, ctrl_readRegB  in  AW  read indices
- data_readRegA, data_readRegB  out  DATA_WIDTH  read data (combinational)
- hw_in  in  NUM_IN  asynchronous buttons/switches; bit i maps to register IN_BASE+i
- hw_out  out  NUM_OUT*DATA_WIDTH  register OUT_BASE+j appears at bits [j*DATA_WIDTH +: DATA_WIDTH]
- event_pending  out  1  OR of all sticky bits

## Operation
- Register classes:
  - Register 0: reads 0; writes ignored.
  - Input registers (IN_BASE..IN_BASE+NUM_IN-1): bit 0 holds the channel value; upper bits read 0.
  - All other registers, including exported ones: plain storage.
- Write: when ctrl_writeEnable=1 at a rising edge, plain storage at ctrl_writeReg loads data_writeReg.
- Input channel path: 2-flop synchroniser s1 <= hw_in[i], s2 <= s1; rise = s1 & ~s2.
  - Level channel: register value = s2. Writes are ignored.
  - Sticky channel: flag <= 1 on rise. A write of any data to that index clears the flag. If rise and clearing write occur in the same cycle, set wins (no lost event).
- Bypass (BYPASS=1): if ctrl_writeEnable=1 and the read index equals ctrl_writeReg and the index is plain storage, read data = data_writeReg. No bypass for register 0 or input registers.
- Out-of-range indices do not exist: NUM_REGS is a power of two.
- Elaboration error if the input and output windows overlap, include index 0, or exceed NUM_REGS-1.

## Timing
- Reset (synchronous, ctrl_reset=1 at an edge): all storage, s1, s2 and sticky flags go to 0.
  - Consequently hw_out = 0 and event_pending = 0.
  - data_read* reflects the zeroed state in the cycle after the reset edge.
- Reset has priority over write and rise in the same cycle.
- A hw_in held high through reset release is seen as a new rising edge; the sticky flag sets 2 edges after the first non-reset edge.
- Input latency: hw_in rises before edge k, giving s1=1 after k and s2=1 after k+1. Both level value and sticky flag are readable after edge k+1 (2 edges).
- Write latency: data is visible on the read ports the cycle after the write edge. With BYPASS=1 it is visible in the same cycle.
- hw_out and event_pending are direct flop outputs, with no extra stage.
- Sticky re-arm: after a clear, a flag sets again only on a new 0→1 transition of s2's input (s1 & ~s2).

## Structure
- Shared package regfile_pkg:
  - default map constants: IN_BASE=1, OUT_BASE=11, NUM_OUT=4
  - named indices for the up/down/left/right/demo/demo2 channels
  - a clog2 function
- One sub-module, io_sync_channel: synchroniser, edge detect, sticky flag, clear input and mode parameter; instantiated NUM_IN times by generate.
- The storage array and read muxes live in the top module (case/index mux; no tristates).

## Test plan
- Reset with writes to r5=0xDEADBEEF and r11=0x5 pending, then release → all reads 0, hw_out=0, event_pending=0.
- Write r11=0x7, r14=0xFFFFFFFF → hw_out[31:0]=0x7 and hw_out[127:96]=0xFFFFFFFF one cycle later. Write r0=0x1234 → r0 reads 0.
- Pulse hw_in[0] (sticky) high for 1 cycle before edge k → r1 reads 1 after edge k+1 and stays 1 after the input falls; event_pending=1. Write r1 → reads 0 and event_pending=0.
- hw_in[0] rising edge coincides with a clearing write to r1 → r1 remains 1.
- Level channel hw_in[4] (r5 with default map adjusted: IN_BASE=1 gives r5) toggles 1/0 → r5 follows with 2-edge lag. A write to r5 of 0xABCD is ignored.
- BYPASS=1: write r7=0x55 with ctrl_readRegA=7 in the same cycle → data_readRegA=0x55 combinationally. With BYPASS=0 → old value until the next cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared map constants and helpers for the memory-mapped register file.
// Channel names follow the board wiring of the default input window.
package regfile_pkg;

   localparam int DEF_IN_BASE  = 1;
   localparam int DEF_OUT_BASE = 11;
   localparam int DEF_NUM_OUT  = 4;

   typedef enum int {
      CH_UP    = 0,
      CH_DOWN  = 1,
      CH_LEFT  = 2,
      CH_RIGHT = 3,
      CH_DEMO  = 4,
      CH_DEMO2 = 5
   } in_channel_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/io_sync_channel.sv
// One board input channel: two-flop synchroniser, rising-edge detect and an
// optional sticky flag that software clears by writing the channel's register.
module io_sync_channel #(
   parameter bit STICKY = 1'b1
) (
   input  logic clock,
   input  logic ctrl_reset,
   input  logic hw_in,
   input  logic clr,
   output logic value,
   output logic pending
);

   logic s1_q, s1_d;
   logic s2_q, s2_d;
   logic flag_q, flag_d;
   logic rise;

   always_comb begin
      s1_d   = hw_in;
      s2_d   = s1_q;
      rise   = s1_q & ~s2_q;
      flag_d = flag_q;
      if (clr)  flag_d = 1'b0;
      // A rise in the same cycle as a clear must not be lost.
      if (rise) flag_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         flag_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         flag_q <= flag_d;
      end
   end

   assign value   = STICKY ? flag_q : s2_q;
   assign pending = STICKY ? flag_q : 1'b0;

endmodule

// File: rtl/mmio_regfile.sv
// Register file with two combinational read ports, one write port, r0 tied to
// zero, a window of board-input registers and a window exported to hw_out.
module mmio_regfile
   import regfile_pkg::*;
#(
   parameter int                 DATA_WIDTH  = 32,
   parameter int                 NUM_REGS    = 32,
   parameter int                 IN_BASE     = DEF_IN_BASE,
   parameter int                 NUM_IN      = 6,
   parameter logic [NUM_IN-1:0]  STICKY_MASK = 6'b001111,
   parameter int                 OUT_BASE    = DEF_OUT_BASE,
   parameter int                 NUM_OUT     = DEF_NUM_OUT,
   parameter bit                 BYPASS      = 1'b1,
   localparam int                AW          = clog2(NUM_REGS)
) (
   input  logic                          clock,
   input  logic                          ctrl_reset,
   input  logic                          ctrl_writeEnable,
   input  logic [AW-1:0]                 ctrl_writeReg,
   input  logic [DATA_WIDTH-1:0]         data_writeReg,
   input  logic [AW-1:0]                 ctrl_readRegA,
   input  logic [AW-1:0]                 ctrl_readRegB,
   output logic [DATA_WIDTH-1:0]         data_readRegA,
   output logic [DATA_WIDTH-1:0]         data_readRegB,
   input  logic [NUM_IN-1:0]             hw_in,
   output logic [NUM_OUT*DATA_WIDTH-1:0] hw_out,
   output logic                          event_pending
);

   if (NUM_REGS < 8 || (1 << AW) != NUM_REGS) begin : g_bad_size
      $error("NUM_REGS must be a power of two and at least 8");
   end
   if (IN_BASE < 1 || OUT_BASE < 1 || IN_BASE + NUM_IN > NUM_REGS ||
       OUT_BASE + NUM_OUT > NUM_REGS) begin : g_bad_range
      $error("I/O windows must exclude r0 and fit inside the register file");
   end
   if (IN_BASE < OUT_BASE + NUM_OUT && OUT_BASE < IN_BASE + NUM_IN) begin : g_bad_overlap
      $error("input and output windows overlap");
   end

   function automatic logic is_plain(input logic [AW-1:0] idx);
      int v;
      v = int'(idx);
      return (v != 0) && !(v >= IN_BASE && v < IN_BASE + NUM_IN);
   endfunction

   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [NUM_IN-1:0]                   ch_val, ch_pend, ch_clr;
   logic                                wr_plain;

   assign wr_plain = ctrl_writeEnable && is_plain(ctrl_writeReg);

   for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
      assign ch_clr[i] = ctrl_writeEnable && (ctrl_writeReg == AW'(IN_BASE + i));
      io_sync_channel #(.STICKY(STICKY_MASK[i])) u_ch (
         .clock      (clock),
         .ctrl_reset (ctrl_reset),
         .hw_in      (hw_in[i]),
         .clr        (ch_clr[i]),
         .value      (ch_val[i]),
         .pending    (ch_pend[i])
      );
   end

   // Only plain storage ever loads; r0 and input slots stay at their reset zero.
   always_comb begin
      regs_d = regs_q;
      if (wr_plain) regs_d[ctrl_writeReg] = data_writeReg;
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) regs_q <= '0;
      else            regs_q <= regs_d;
   end

   always_comb begin
      data_readRegA = regs_q[ctrl_readRegA];
      data_readRegB = regs_q[ctrl_readRegB];
      if (BYPASS && wr_plain) begin
         if (ctrl_readRegA == ctrl_writeReg) data_readRegA = data_writeReg;
         if (ctrl_readRegB == ctrl_writeReg) data_readRegB = data_writeReg;
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (ctrl_readRegA == AW'(IN_BASE + i))
            data_readRegA = {{(DATA_WIDTH-1){1'b0}}, ch_val[i]};
         if (ctrl_readRegB == AW'(IN_BASE + i))
            data_readRegB = {{(DATA_WIDTH-1){1'b0}}, ch_val[i]};
      end
   end

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      assign hw_out[j*DATA_WIDTH +: DATA_WIDTH] = regs_q[OUT_BASE + j];
   end

   assign event_pending = |ch_pend;

endmodule

// File: tb/tb_mmio_regfile.sv
// Bench for mmio_regfile: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_mmio_regfile;

   localparam int DW = 32;
   localparam int NR = 32;
   localparam int AW = 5;
   localparam int IB = 1;
   localparam int NI = 6;
   localparam int OB = 11;
   localparam int NO = 4;
   localparam logic [NI-1:0] SM = 6'b001111;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            we = 1'b0;
   logic [AW-1:0]   wr = '0;
   logic [DW-1:0]   wd = '0;
   logic [AW-1:0]   ra = '0, rb = '0;
   logic [NI-1:0]   hw = '0;

   logic [DW-1:0]    rda1, rdb1, rda0, rdb0;
   logic [NO*DW-1:0] out1, out0;
   logic             ev1, ev0;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   mmio_regfile #(.BYPASS(1'b1)) dut_byp (
      .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
      .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
      .data_readRegA(rda1), .data_readRegB(rdb1), .hw_in(hw), .hw_out(out1),
      .event_pending(ev1));

   mmio_regfile #(.BYPASS(1'b0)) dut_nobyp (
      .clock(clk), .ctrl_reset(rst), .ctrl_writeEnable(we), .ctrl_writeReg(wr),
      .data_writeReg(wd), .ctrl_readRegA(ra), .ctrl_readRegB(rb),
      .data_readRegA(rda0), .data_readRegB(rdb0), .hw_in(hw), .hw_out(out0),
      .event_pending(ev0));

   // Behavioural model: memory array, sampled input history and sticky flags.
   logic [DW-1:0] m_mem [NR];
   logic [NI-1:0] seen1, seen2, m_flag;

   function automatic bit in_win(input int idx);
      return idx >= IB && idx < IB + NI;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NR; i++) m_mem[i] = '0;
         seen1 = '0; seen2 = '0; m_flag = '0;
      end else begin
         if (we && wr != 0 && !in_win(int'(wr))) m_mem[wr] = wd;
         for (int i = 0; i < NI; i++) begin
            if (SM[i]) begin
               if (we && int'(wr) == IB + i) m_flag[i] = 1'b0;
               if (seen1[i] && !seen2[i]) m_flag[i] = 1'b1;
            end
         end
         seen2 = seen1;
         seen1 = hw;
      end
   end

   function automatic logic [DW-1:0] exp_read(input int idx, input bit byp);
      if (in_win(idx)) begin
         int c;
         c = idx - IB;
         return SM[c] ? DW'(m_flag[c]) : DW'(seen2[c]);
      end
      if (idx == 0) return '0;
      if (byp && we && int'(wr) == idx) return wd;
      return m_mem[idx];
   endfunction

   function automatic logic [NO*DW-1:0] exp_out();
      logic [NO*DW-1:0] v;
      for (int j = 0; j < NO; j++) v[j*DW +: DW] = m_mem[OB + j];
      return v;
   endfunction

   task automatic check(input string name, input logic [NO*DW-1:0] act,
                        input logic [NO*DW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("byp_rdA", rda1, exp_read(int'(ra), 1'b1));
         check("byp_rdB", rdb1, exp_read(int'(rb), 1'b1));
         check("nob_rdA", rda0, exp_read(int'(ra), 1'b0));
         check("nob_rdB", rdb0, exp_read(int'(rb), 1'b0));
         check("byp_hw_out", out1, exp_out());
         check("nob_hw_out", out0, exp_out());
         check("byp_event", ev1, |(m_flag & SM));
         check("nob_event", ev0, |(m_flag & SM));
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   initial begin
      step(); step();
      // Reset with writes pending.
      we = 1'b1; wr = 5'd5; wd = 32'hDEADBEEF; step();
      wr = 5'd11; wd = 32'h5; step();
      rst = 1'b0; we = 1'b0; ra = 5'd5; rb = 5'd11; chk_en = 1'b1;
      settle();
      check("rst_rdA", rda1, 32'h0);
      check("rst_rdB", rdb1, 32'h0);
      check("rst_hw_out", out1, '0);
      check("rst_event", ev1, 1'b0);

      step();
      we = 1'b1; wr = 5'd11; wd = 32'h7; step();
      wr = 5'd14; wd = 32'hFFFFFFFF; step();
      wr = 5'd0; wd = 32'h1234; step();
      we = 1'b0; ra = 5'd0; rb = 5'd14;
      settle();
      check("out_r11", out1[31:0], 32'h7);
      check("out_r14", out1[127:96], 32'hFFFFFFFF);
      check("r0_zero", rda1, 32'h0);
      check("r14_read", rdb1, 32'hFFFFFFFF);

      step();
      ra = 5'd1; hw[0] = 1'b1; step();
      hw[0] = 1'b0; step();
      settle();
      check("sticky_set", rda1, 32'h1);
      check("sticky_event", ev1, 1'b1);
      step(); step();
      settle();
      check("sticky_hold", rda1, 32'h1);
      we = 1'b1; wr = 5'd1; wd = 32'h0; step();
      we = 1'b0;
      settle();
      check("sticky_clear", rda1, 32'h0);
      check("clear_event", ev1, 1'b0);

      step();
      hw[0] = 1'b1; step();
      we = 1'b1; wr = 5'd1; wd = 32'h0; step();
      we = 1'b0;
      settle();
      check("set_wins", rda1, 32'h1);
      hw[0] = 1'b0; step();
      we = 1'b1; wr = 5'd1; step();
      we = 1'b0;

      ra = 5'd5; hw[4] = 1'b1; step();
      settle();
      check("level_lag1", rda1, 32'h0);
      step();
      settle();
      check("level_lag2", rda1, 32'h1);
      we = 1'b1; wr = 5'd5; wd = 32'hABCD; step();
      we = 1'b0;
      settle();
      check("level_wr_ignored", rda1, 32'h1);
      hw[4] = 1'b0; step(); step();
      settle();
      check("level_fall", rda1, 32'h0);

      ra = 5'd7; we = 1'b1; wr = 5'd7; wd = 32'h55;
      #1;
      check("bypass_on", rda1, 32'h55);
      check("bypass_off", rda0, 32'h0);
      step();
      we = 1'b0;
      settle();
      check("nobyp_next", rda0, 32'h55);

      // Randomized traffic; the compare process checks every cycle.
      for (int n = 0; n < 3000; n++) begin
         step();
         rst = ($urandom_range(0, 99) == 0);
         we  = $urandom_range(0, 1);
         wr  = AW'($urandom);
         case ($urandom_range(0, 3))
            0:       wd = '0;
            1:       wd = '1;
            default: wd = $urandom;
         endcase
         ra = AW'($urandom);
         rb = ($urandom_range(0, 3) == 0) ? wr : AW'($urandom);
         for (int i = 0; i < NI; i++)
            if ($urandom_range(0, 7) == 0) hw[i] = ~hw[i];
      end
      step();
      rst = 1'b0; we = 1'b0;
      step();
      settle();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
